// File: rtl/axi_fir_filter.sv
// -----------------------------------------------------------------------------
// axi_fir_filter
//
// Configurable-tap FIR filter. Software loads Q1.15 coefficients and the
// enable bit through an AXI4-Lite slave. Q1.15 samples enter on an AXI4-Stream
// slave and filtered samples leave on an AXI4-Stream master, one cycle after
// input acceptance.
//
// Register map (word index = address[7:0], no byte offset):
//   0          CTRL   bit0 ENABLE (R/W), bit1 FLUSH (write-1 clears the delay
//                     line, self-clearing, reads 0)
//   1..TAPS    COEF[k] 16-bit signed in [15:0], reads sign-extended
//   others     writes ignored, reads 0
//
// Optional build macro:
//   FIR_SATURATE_EN  defined   -> result saturated to 16'h8000..16'h7FFF
//                    undefined -> low 16 bits taken with two's-complement wrap
//
// Ports:
//   s_axi_aclk, s_axi_aresetn     clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*               AXI4-Lite write channels (bresp always OKAY)
//   s_axi_ar*/r*                  AXI4-Lite read channels  (rresp always OKAY)
//   s_axis_*                      input sample stream, sample in tdata[15:0]
//   m_axis_*                      output stream, sample sign-extended, tstrb
//                                 all ones, tlast follows its sample
// -----------------------------------------------------------------------------
module axi_fir_filter #(
  parameter int TAPS                 = 53,
  parameter int C_S_AXI_ADDR_WIDTH   = 32,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                s_axi_aclk,
  input  logic                                s_axi_aresetn,
  // AXI4-Lite write
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s_axi_awaddr,
  input  logic [2:0]                          s_axi_awprot,
  input  logic                                s_axi_awvalid,
  output logic                                s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     s_axi_wstrb,
  input  logic                                s_axi_wvalid,
  output logic                                s_axi_wready,
  output logic [1:0]                          s_axi_bresp,
  output logic                                s_axi_bvalid,
  input  logic                                s_axi_bready,
  // AXI4-Lite read
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s_axi_araddr,
  input  logic [2:0]                          s_axi_arprot,
  input  logic                                s_axi_arvalid,
  output logic                                s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       s_axi_rdata,
  output logic [1:0]                          s_axi_rresp,
  output logic                                s_axi_rvalid,
  input  logic                                s_axi_rready,
  // AXI4-Stream input
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic                                s_axis_tlast,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  // AXI4-Stream output
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = 32 + $clog2(TAPS);

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------
  // Q2.30 accumulator -> Q1.15 with round half up.
  function automatic logic signed [ACC_W-1:0] round_q15(input logic signed [ACC_W-1:0] a);
    return (a + ACC_W'(16384)) >>> 15;
  endfunction

  function automatic logic signed [DATA_W-1:0] reduce16(input logic signed [ACC_W-1:0] r);
`ifdef FIR_SATURATE_EN
    if (r > ACC_W'(32767))
      return 16'sh7FFF;
    else if (r < ACC_W'(-32768))
      return 16'sh8000;
    else
      return DATA_W'(r);
`else
    return DATA_W'(r);
`endif
  endfunction

  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] sext_coef(input logic signed [COEF_W-1:0] c);
    return {{(C_S_AXI_DATA_WIDTH-COEF_W){c[COEF_W-1]}}, c};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                            awready_q, awready_d;
  logic                            bvalid_q,  bvalid_d;
  logic                            arready_q, arready_d;
  logic                            rvalid_q,  rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q,   rdata_d;
  logic                            enable_q,  enable_d;
  logic signed [COEF_W-1:0]        coef_q [TAPS];
  logic signed [COEF_W-1:0]        coef_d [TAPS];
  logic signed [DATA_W-1:0]        x_q    [TAPS];
  logic signed [DATA_W-1:0]        x_d    [TAPS];
  logic                            m_tvalid_q, m_tvalid_d;
  logic signed [DATA_W-1:0]        m_tdata_q,  m_tdata_d;
  logic                            m_tlast_q,  m_tlast_d;

  // Combinational helpers
  logic [7:0]                      wr_idx, rd_idx;
  logic                            wr_fire, rd_fire, in_ready, in_fire, flush;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rd_word;
  logic signed [DATA_W-1:0]        x_new  [TAPS];
  logic signed [PROD_W-1:0]        prod;
  logic signed [ACC_W-1:0]         acc;

  assign wr_idx   = s_axi_awaddr[7:0];
  assign rd_idx   = s_axi_araddr[7:0];
  assign wr_fire  = awready_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire  = arready_q & s_axi_arvalid;
  assign in_ready = enable_q & (~m_tvalid_q | m_axis_tready);
  assign in_fire  = in_ready & s_axis_tvalid;

  // ---------------------------------------------------------------------------
  // AXI4-Lite handshakes. Ready pulses are registered; the extra !ready term
  // keeps a pulse from re-arming while the master still holds valid during
  // the handshake cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    awready_d = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
    bvalid_d  = bvalid_q;
    if (wr_fire)
      bvalid_d = 1'b1;
    else if (s_axi_bready)
      bvalid_d = 1'b0;

    arready_d = s_axi_arvalid & ~rvalid_q & ~arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
    end else if (s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Read mux sees pre-write state, so a same-cycle read returns the old value.
  always_comb begin
    rd_word = '0;
    if (rd_idx == 8'd0)
      rd_word[0] = enable_q;
    for (int k = 0; k < TAPS; k++) begin
      if (int'(rd_idx) == k + 1)
        rd_word = sext_coef(coef_q[k]);
    end
  end

  // Register writes, byte lanes gated by wstrb. FLUSH is never stored.
  always_comb begin
    enable_d = enable_q;
    flush    = 1'b0;
    for (int k = 0; k < TAPS; k++)
      coef_d[k] = coef_q[k];
    if (wr_fire) begin
      if (wr_idx == 8'd0 && s_axi_wstrb[0]) begin
        enable_d = s_axi_wdata[0];
        flush    = s_axi_wdata[1];
      end
      for (int k = 0; k < TAPS; k++) begin
        if (int'(wr_idx) == k + 1) begin
          if (s_axi_wstrb[0]) coef_d[k][7:0]  = s_axi_wdata[7:0];
          if (s_axi_wstrb[1]) coef_d[k][15:8] = s_axi_wdata[15:8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: the MAC runs over the delay line as it will look after the
  // incoming sample is shifted in, so the output for a sample is ready one
  // cycle after acceptance.
  // ---------------------------------------------------------------------------
  always_comb begin
    x_new[0] = s_axis_tdata[DATA_W-1:0];
    for (int k = 1; k < TAPS; k++)
      x_new[k] = x_q[k-1];

    acc  = '0;
    prod = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod = PROD_W'(coef_q[k]) * PROD_W'(x_new[k]);
      acc  = acc + ACC_W'(prod);
    end

    // Flush wins over a same-cycle shift; the accepted sample still gets its
    // output computed from the pre-flush history.
    for (int k = 0; k < TAPS; k++)
      x_d[k] = in_fire ? x_new[k] : x_q[k];
    if (flush)
      for (int k = 0; k < TAPS; k++)
        x_d[k] = '0;

    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    if (in_fire) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = reduce16(round_q15(acc));
      m_tlast_d  = s_axis_tlast;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  // ---- register stage: control, coefficients, delay line, output ----
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      enable_q   <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= 16'sd1;
        x_q[k]    <= '0;
      end
    end else begin
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      enable_q   <= enable_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= coef_d[k];
        x_q[k]    <= x_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axis_tready = in_ready;
  assign m_axis_tdata  = {{(C_M_AXIS_TDATA_WIDTH-DATA_W){m_tdata_q[DATA_W-1]}}, m_tdata_q};
  assign m_axis_tstrb  = '1;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tvalid = m_tvalid_q;

  // Inputs the register map and stream format deliberately ignore. The oldest
  // delay-line entry is kept for visibility but never feeds the MAC.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:8],
                           s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:8],
                           s_axi_wdata[C_S_AXI_DATA_WIDTH-1:16],
                           s_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:2],
                           s_axis_tdata[C_S_AXIS_TDATA_WIDTH-1:DATA_W],
                           s_axis_tstrb, x_q[TAPS-1]};

endmodule

// File: tb/tb_axi_fir_filter.sv
`timescale 1ns/1ps
module tb_axi_fir_filter;
  localparam int TAPS = 53;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axis_tdata, m_axis_tdata;
  logic [3:0]  s_axis_tstrb, m_axis_tstrb;
  logic        s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic        m_axis_tlast, m_axis_tvalid, m_axis_tready;

  always #5 clk = ~clk;

  axi_fir_filter #(.TAPS(TAPS)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int data; bit last; } out_t;
  int   coef_m [TAPS];
  int   hist [$];        // hist[0] newest sample; missing entries are zero
  out_t exp_q [$];
  int   n_in = 0, n_out = 0;

  function automatic int model_step(input int s);
    longint acc;
    hist.push_front(s);
    if (hist.size() > TAPS) void'(hist.pop_back());
    acc = 0;
    foreach (hist[i]) acc += longint'(coef_m[i]) * longint'(hist[i]);
    acc = (acc + 16384) >>> 15;
`ifdef FIR_SATURATE_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`else
    acc = acc & 64'hFFFF;
    if (acc >= 32768) acc = acc - 65536;
`endif
    return int'(acc);
  endfunction

  // Monitor: outputs consumed and inputs accepted at the next rising edge.
  bit acc_prev = 0;
  always @(negedge clk) begin
    out_t o;
    if (!rst_n) begin
      acc_prev = 0;
    end else begin
      if (acc_prev) chk("latency_tvalid", longint'(m_axis_tvalid), 1);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", longint'(exp_q.size()), 1);
        end else begin
          o = exp_q.pop_front();
          chk("out_data", longint'(signed'(m_axis_tdata)), o.data);
          chk("out_last", longint'(m_axis_tlast), longint'(o.last));
          n_out++;
        end
      end
      acc_prev = s_axis_tvalid && s_axis_tready;
      if (acc_prev) begin
        o.data = model_step(int'($signed(s_axis_tdata[15:0])));
        o.last = s_axis_tlast;
        exp_q.push_back(o);
        n_in++;
      end
    end
  end

  // ---------------- drivers ----------------
  bit rand_bp = 0;

  task automatic tick();
    @(posedge clk); #1;
    if (rand_bp) m_axis_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    bit hs = 0;
    s_axi_awaddr = 32'(idx); s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    for (int n = 0; n < 16 && !hs; n++) begin
      @(negedge clk); hs = s_axi_awready && s_axi_wready; tick();
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    if (!hs) chk("aw_handshake", longint'(hs), 1);
    hs = 0; s_axi_bready = 1;
    for (int n = 0; n < 16 && !hs; n++) begin
      @(negedge clk); hs = s_axi_bvalid;
      if (hs) chk("bresp", longint'(s_axi_bresp), 0);
      tick();
    end
    s_axi_bready = 0;
    if (!hs) chk("b_handshake", longint'(hs), 1);
  endtask

  task automatic rd_chk(input string tag, input int idx, input longint exp);
    bit hs = 0;
    logic [31:0] d = '0;
    s_axi_araddr = 32'(idx); s_axi_arvalid = 1;
    for (int n = 0; n < 16 && !hs; n++) begin
      @(negedge clk); hs = s_axi_arready; tick();
    end
    s_axi_arvalid = 0;
    if (!hs) chk("ar_handshake", longint'(hs), 1);
    hs = 0; s_axi_rready = 1;
    for (int n = 0; n < 16 && !hs; n++) begin
      @(negedge clk); hs = s_axi_rvalid;
      if (hs) begin d = s_axi_rdata; chk("rresp", longint'(s_axi_rresp), 0); end
      tick();
    end
    s_axi_rready = 0;
    chk(tag, longint'(signed'(d)), exp);
  endtask

  task automatic send(input int s, input bit last);
    bit hs = 0;
    s_axis_tdata = {16'($urandom), 16'(s)};
    s_axis_tlast = last; s_axis_tvalid = 1;
    for (int n = 0; n < 64 && !hs; n++) begin
      @(negedge clk); hs = s_axis_tready; tick();
    end
    if (!hs) chk("in_accept", longint'(hs), 1);
  endtask

  task automatic idle_drain();
    s_axis_tvalid = 0; s_axis_tlast = 0;
    rand_bp = 0; m_axis_tready = 1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
    tick();
    chk("drained", longint'(exp_q.size()), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    s_axi_awaddr = 0; s_axi_awprot = 0; s_axi_awvalid = 0; s_axi_wdata = 0;
    s_axi_wstrb = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = 0;
    s_axi_arprot = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    s_axis_tdata = 0; s_axis_tstrb = 0; s_axis_tlast = 0; s_axis_tvalid = 0;
    m_axis_tready = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Reset state
    @(negedge clk);
    chk("rst_s_tready", longint'(s_axis_tready), 0);
    chk("rst_m_tvalid", longint'(m_axis_tvalid), 0);
    chk("rst_m_tdata",  longint'(m_axis_tdata), 0);
    chk("rst_m_tlast",  longint'(m_axis_tlast), 0);
    chk("rst_tstrb",    longint'(m_axis_tstrb), 15);
    chk("rst_bvalid",   longint'(s_axi_bvalid), 0);
    chk("rst_rvalid",   longint'(s_axi_rvalid), 0);
    tick();
    for (int k = 1; k <= TAPS; k++) rd_chk("rst_coef", k, 1);
    rd_chk("rst_ctrl", 0, 0);

    // Register round trip
    for (int k = 1; k <= TAPS; k++) begin
      axi_write(k, 32'(k * 3), 4'hF); coef_m[k-1] = k * 3;
    end
    for (int k = 1; k <= TAPS; k++) rd_chk("coef_roundtrip", k, k * 3);
    axi_write(60, 32'hDEADBEEF, 4'hF);
    rd_chk("idx60_read", 60, 0);
    axi_write(5, 32'h0000ABCD, 4'b0001);
    rd_chk("strb_low_byte", 5, 32'h00CD);
    axi_write(5, 32'h00008000, 4'b0010);
    rd_chk("strb_high_sext", 5, -32563);
    axi_write(5, 32'd15, 4'hF);
    axi_write(6, 32'h0010, 4'hF); coef_m[5] = 16;
    axi_write(0, 32'd1, 4'hF);
    rd_chk("ctrl_enable", 0, 1);

    // Impulse response
    m_axis_tready = 1;
    send(32767, 0);
    for (int i = 0; i < TAPS - 1; i++) send(0, 0);
    idle_drain();

    // Reference run: triangular low-pass, noisy square input, random backpressure
    for (int k = 1; k <= TAPS; k++) begin
      int c = 1100 - 38 * ((k > 27) ? (k - 27) : (27 - k));
      axi_write(k, 32'(c), 4'hF); coef_m[k-1] = c;
    end
    axi_write(0, 32'd3, 4'hF); hist.delete();
    rand_bp = 1;
    for (int i = 0; i < 1024; i++) begin
      int s = int'($urandom_range(0, 8191)) - 4096 + (((i / 32) % 2 == 1) ? 12000 : -12000);
      send(s, i == 1023);
    end
    idle_drain();

    // Backpressure: output held stable, input stalled
    m_axis_tready = 0;
    send(1000, 0);
    s_axis_tdata = 32'd2000;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_tvalid", longint'(m_axis_tvalid), 1);
      chk("bp_tdata", longint'(signed'(m_axis_tdata)), exp_q.size() ? exp_q[0].data : -99999);
      chk("bp_s_tready", longint'(s_axis_tready), 0);
      tick();
    end
    m_axis_tready = 1;
    send(2000, 0);
    send(3000, 1);
    idle_drain();

    // Clearing ENABLE: pending output delivered, history retained
    m_axis_tready = 0;
    send(-500, 0);
    s_axis_tvalid = 0;
    axi_write(0, 32'd0, 4'hF);
    @(negedge clk);
    m_axis_tready = 1;
    chk("disabled_s_tready", longint'(s_axis_tready), 0);
    tick();
    idle_drain();
    axi_write(0, 32'd1, 4'hF);
    send(600, 0);
    idle_drain();

    // Overflow: all coefficients at full scale
    for (int k = 1; k <= TAPS; k++) begin
      axi_write(k, 32'h7FFF, 4'hF); coef_m[k-1] = 32767;
    end
    axi_write(0, 32'd3, 4'hF); hist.delete();
    rd_chk("ctrl_flush_reads0", 0, 1);
    for (int i = 0; i < TAPS; i++) send(32767, 0);
    idle_drain();
    axi_write(0, 32'd3, 4'hF); hist.delete();
    send(0, 0);
    idle_drain();
    chk("in_out_count", n_out, n_in);

    // Reset mid-operation drops the pending output
    m_axis_tready = 0;
    send(1234, 0);
    s_axis_tvalid = 0;
    #2 rst_n = 0;
    exp_q.delete(); hist.delete();
    #1;
    chk("midrst_m_tvalid", longint'(m_axis_tvalid), 0);
    chk("midrst_m_tdata",  longint'(m_axis_tdata), 0);
    chk("midrst_s_tready", longint'(s_axis_tready), 0);
    tick(); tick();
    rst_n = 1;
    tick();
    rd_chk("midrst_coef", 1, 1);
    rd_chk("midrst_ctrl", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
